// File: rtl/logic_issue_queue_pkg.sv
// -----------------------------------------------------------------------------
// logic_pkg
// Shared definitions for the logic-unit issue path.
//   - LOP_* opcode encodings (all 8 encodings are legal and passed through)
//   - DATA_W / REG_AW default widths of the logic-unit slot
//   - entry_t : one decoded logic instruction {op, a, b, rd}
// -----------------------------------------------------------------------------
package logic_pkg;

  localparam int DATA_W = 32;
  localparam int REG_AW = 5;

  typedef enum logic [2:0] {
    LOP_AND  = 3'b000,
    LOP_XOR  = 3'b001,
    LOP_NAND = 3'b010,
    LOP_OR   = 3'b011,
    LOP_NOT  = 3'b100,
    LOP_NOR  = 3'b101,
    LOP_NEG  = 3'b110,
    LOP_XNOR = 3'b111
  } lop_e;

  typedef struct packed {
    logic [2:0]        op;
    logic [DATA_W-1:0] a;
    logic [DATA_W-1:0] b;
    logic [REG_AW-1:0] rd;
  } entry_t;

endpackage

// File: rtl/logic_issue_queue_if.sv
// -----------------------------------------------------------------------------
// logic_issue_queue_if
// Bundles the decoder-side handshake, pipeline controls, logic-unit drive and
// writeback signals of logic_issue_queue.
//   master : decoder / pipeline control side (drives in_*, hold, flush)
//   slave  : the issue queue (drives in_ready, lu_*, wb_*, count)
//
// Handshake: an instruction transfers on a rising clk edge where
// in_valid && in_ready. in_ready depends only on registered occupancy, never on
// in_valid, so the decoder may hold in_valid with stable payload until taken.
// hold and flush are level controls sampled on the same edge.
// -----------------------------------------------------------------------------
interface logic_issue_queue_if #(
  parameter int DEPTH  = 4,
  parameter int DATA_W = logic_pkg::DATA_W,
  parameter int REG_AW = logic_pkg::REG_AW
);
  localparam int CNT_W = $clog2(DEPTH + 1);

  logic              in_valid;
  logic              in_ready;
  logic [2:0]        in_op;
  logic [DATA_W-1:0] in_a;
  logic [DATA_W-1:0] in_b;
  logic [REG_AW-1:0] in_rd;
  logic              hold;
  logic              flush;
  logic [2:0]        lu_op;
  logic [DATA_W-1:0] lu_a;
  logic [DATA_W-1:0] lu_b;
  logic              wb_valid;
  logic [REG_AW-1:0] wb_rd;
  logic [CNT_W-1:0]  count;

  modport master (
    output in_valid, in_op, in_a, in_b, in_rd, hold, flush,
    input  in_ready, lu_op, lu_a, lu_b, wb_valid, wb_rd, count
  );

  modport slave (
    input  in_valid, in_op, in_a, in_b, in_rd, hold, flush,
    output in_ready, lu_op, lu_a, lu_b, wb_valid, wb_rd, count
  );

endinterface

// File: rtl/logic_issue_queue_fifo.sv
// -----------------------------------------------------------------------------
// logic_fifo
// Generic DEPTH-entry FIFO (DEPTH a power of two, >= 2) with flush.
//   clk, rst_n : clock, synchronous active-low reset
//   push/wdata : write at tail; ignored when full
//   pop        : advance head; ignored when empty
//   flush      : empties the FIFO; overrides push and pop
//   rdata      : head entry (combinational read of storage)
//   count      : registered occupancy
// -----------------------------------------------------------------------------
module logic_fifo #(
  parameter int DEPTH = 4,
  parameter int W     = 8,
  localparam int CNT_W = $clog2(DEPTH + 1),
  localparam int PTR_W = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic             pop,
  input  logic             flush,
  input  logic [W-1:0]     wdata,
  output logic [W-1:0]     rdata,
  output logic [CNT_W-1:0] count
);

  logic [PTR_W-1:0] head_q, head_d;
  logic [PTR_W-1:0] tail_q, tail_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic [W-1:0]     mem_q [DEPTH];
  logic [W-1:0]     mem_d [DEPTH];
  logic             push_ok, pop_ok;

  always_comb begin
    push_ok = push && (count_q != CNT_W'(DEPTH));
    pop_ok  = pop && (count_q != '0);
    head_d  = head_q;
    tail_d  = tail_q;
    count_d = count_q;
    mem_d   = mem_q;
    if (flush) begin
      head_d  = '0;
      tail_d  = '0;
      count_d = '0;
    end else begin
      if (push_ok) begin
        mem_d[tail_q] = wdata;
        tail_d        = tail_q + PTR_W'(1);  // power-of-two depth: natural wrap
      end
      if (pop_ok) begin
        head_d = head_q + PTR_W'(1);
      end
      case ({push_ok, pop_ok})
        2'b10:   count_d = count_q + CNT_W'(1);
        2'b01:   count_d = count_q - CNT_W'(1);
        default: count_d = count_q;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else begin
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
    end
  end

  // Storage needs no reset: occupancy alone decides what is live.
  always_ff @(posedge clk) begin
    mem_q <= mem_d;
  end

  assign rdata = mem_q[head_q];
  assign count = count_q;

endmodule

// File: rtl/logic_issue_queue.sv
// -----------------------------------------------------------------------------
// logic_issue_queue
// Issue stage in front of the VLIW logic-unit slot. Decoded instructions are
// buffered in a DEPTH-entry FIFO and issued one per cycle onto lu_op/lu_a/lu_b.
// The destination register rides a stage-1 register alongside the operands and
// then a writeback register, so wb_valid/wb_rd line up with the logic unit's
// registered result.
//   clk, rst_n : clock, synchronous active-low reset
//   bus        : logic_issue_queue_if.slave (in_* handshake, hold, flush,
//                lu_* drive, wb_valid/wb_rd, count)
// Optional build macro LOGIC_BYPASS_EN: an instruction offered while the queue
// is empty (and neither hold nor flush) issues straight onto lu_* at its accept
// edge, skipping the FIFO and saving one cycle of latency.
// -----------------------------------------------------------------------------
module logic_issue_queue
  import logic_pkg::*;
#(
  parameter int DEPTH  = 4,
  parameter int DATA_W = logic_pkg::DATA_W,
  parameter int REG_AW = logic_pkg::REG_AW
) (
  input logic                 clk,
  input logic                 rst_n,
  logic_issue_queue_if.slave  bus
);

  localparam int CNT_W = $clog2(DEPTH + 1);

  typedef struct packed {
    logic [2:0]        op;
    logic [DATA_W-1:0] a;
    logic [DATA_W-1:0] b;
    logic [REG_AW-1:0] rd;
  } q_entry_t;

  localparam int ENTRY_W = $bits(q_entry_t);

  q_entry_t           in_entry, head_entry, issue_entry;
  logic [ENTRY_W-1:0] fifo_rdata;
  logic [CNT_W-1:0]   count;
  logic               in_ready, do_pop, do_bypass, do_push, do_issue;

  logic [2:0]        lu_op_q, lu_op_d;
  logic [DATA_W-1:0] lu_a_q, lu_a_d;
  logic [DATA_W-1:0] lu_b_q, lu_b_d;
  logic              s1_v_q, s1_v_d;
  logic [REG_AW-1:0] s1_rd_q, s1_rd_d;
  logic              wb_v_q, wb_v_d;
  logic [REG_AW-1:0] wb_rd_q, wb_rd_d;

  assign in_entry   = '{op: bus.in_op, a: bus.in_a, b: bus.in_b, rd: bus.in_rd};
  assign head_entry = q_entry_t'(fifo_rdata);

  always_comb begin
    // Ready from registered occupancy only: a same-cycle pop cannot free a slot.
    in_ready = (count != CNT_W'(DEPTH));
    do_pop   = (count != '0) && !bus.hold && !bus.flush;
`ifdef LOGIC_BYPASS_EN
    do_bypass = (count == '0) && bus.in_valid && !bus.hold && !bus.flush;
`else
    do_bypass = 1'b0;
`endif
    // flush drops any push offered alongside it; a bypassed instruction never
    // enters the FIFO.
    do_push     = bus.in_valid && in_ready && !bus.flush && !do_bypass;
    do_issue    = do_pop || do_bypass;
    issue_entry = do_bypass ? in_entry : head_entry;
  end

  logic_fifo #(
    .DEPTH (DEPTH),
    .W     (ENTRY_W)
  ) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (do_push),
    .pop   (do_pop),
    .flush (bus.flush),
    .wdata (in_entry),
    .rdata (fifo_rdata),
    .count (count)
  );

  always_comb begin
    lu_op_d = lu_op_q;
    lu_a_d  = lu_a_q;
    lu_b_d  = lu_b_q;
    s1_rd_d = s1_rd_q;
    s1_v_d  = do_issue;
    // The stage-1 instruction is the one the logic unit captures at this edge;
    // flush squashes it, but a writeback already on the bus is left alone.
    wb_v_d  = s1_v_q && !bus.flush;
    wb_rd_d = s1_rd_q;
    if (do_issue) begin
      lu_op_d = issue_entry.op;
      lu_a_d  = issue_entry.a;
      lu_b_d  = issue_entry.b;
      s1_rd_d = issue_entry.rd;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      lu_op_q <= '0;
      lu_a_q  <= '0;
      lu_b_q  <= '0;
      s1_v_q  <= 1'b0;
      s1_rd_q <= '0;
      wb_v_q  <= 1'b0;
      wb_rd_q <= '0;
    end else begin
      lu_op_q <= lu_op_d;
      lu_a_q  <= lu_a_d;
      lu_b_q  <= lu_b_d;
      s1_v_q  <= s1_v_d;
      s1_rd_q <= s1_rd_d;
      wb_v_q  <= wb_v_d;
      wb_rd_q <= wb_rd_d;
    end
  end

  assign bus.in_ready = in_ready;
  assign bus.count    = count;
  assign bus.lu_op    = lu_op_q;
  assign bus.lu_a     = lu_a_q;
  assign bus.lu_b     = lu_b_q;
  assign bus.wb_valid = wb_v_q;
  assign bus.wb_rd    = wb_rd_q;

endmodule

// File: tb/tb_logic_issue_queue.sv
// -----------------------------------------------------------------------------
// tb_logic_issue_queue
// Directed bench for logic_issue_queue. A behavioural logic unit captures lu_*
// each edge; every writeback is matched against an expected {rd, result} queue
// filled when stimulus is issued. Directed checks cover reset, latency, full,
// hold, flush and mid-operation reset. Build with +define+LOGIC_BYPASS_EN to
// exercise the bypass variant.
// -----------------------------------------------------------------------------
module tb_logic_issue_queue;
  import logic_pkg::*;

  localparam int DEPTH = 4;
  localparam int DW    = 32;
  localparam int RW    = 5;
`ifdef LOGIC_BYPASS_EN
  localparam int WB_LAT        = 1;
  localparam int CNT_AFTER_ACC = 0;
`else
  localparam int WB_LAT        = 2;
  localparam int CNT_AFTER_ACC = 1;
`endif

  typedef struct packed {
    logic [2:0]    op;
    logic [DW-1:0] a;
    logic [DW-1:0] b;
    logic [RW-1:0] rd;
    logic [DW-1:0] res;
  } vec_t;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic_issue_queue_if #(.DEPTH(DEPTH), .DATA_W(DW), .REG_AW(RW)) bus ();

  logic_issue_queue #(.DEPTH(DEPTH), .DATA_W(DW), .REG_AW(RW)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  // ---------------- downstream logic unit model ----------------
  function automatic logic [DW-1:0] lu_eval(logic [2:0] op, logic [DW-1:0] a, logic [DW-1:0] b);
    case (lop_e'(op))
      LOP_AND:  return a & b;
      LOP_XOR:  return a ^ b;
      LOP_NAND: return ~(a & b);
      LOP_OR:   return a | b;
      LOP_NOT:  return ~a;
      LOP_NOR:  return ~(a | b);
      LOP_NEG:  return -a;
      LOP_XNOR: return ~(a ^ b);
      default:  return '0;
    endcase
  endfunction

  logic [DW-1:0] lu_out;
  always @(posedge clk) lu_out <= lu_eval(bus.lu_op, bus.lu_a, bus.lu_b);

  // ---------------- scoreboard ----------------
  logic [RW+DW-1:0] exp_q[$];
  int checks = 0;
  int errors = 0;

  task automatic check(string name, logic [63:0] act, logic [63:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0h, required %0h", name, act, req);
    end
  endtask

  always @(negedge clk) begin
    if (bus.wb_valid === 1'b1) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL wb_unexpected: got rd=%0d res=%0h, required no writeback", bus.wb_rd, lu_out);
      end else begin
        check("wb_result", {bus.wb_rd, lu_out}, exp_q.pop_front());
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(vec_t v);
    bus.in_valid = 1'b1;
    bus.in_op    = v.op;
    bus.in_a     = v.a;
    bus.in_b     = v.b;
    bus.in_rd    = v.rd;
  endtask

  task automatic idle();
    bus.in_valid = 1'b0;
  endtask

  task automatic expect_wb(vec_t v);
    exp_q.push_back({v.rd, v.res});
  endtask

  // One instruction into an empty, unstalled queue; checks accept-to-wb latency.
  task automatic single(vec_t v);
    drive(v);
    expect_wb(v);
    check("single_ready", bus.in_ready, 1);
    tick();
    idle();
    check("single_count", bus.count, CNT_AFTER_ACC);
    for (int i = 0; i < WB_LAT; i++) begin
      check("single_wb_early", bus.wb_valid, 0);
      tick();
    end
    check("single_wb_valid", bus.wb_valid, 1);
    check("single_wb_rd", bus.wb_rd, v.rd);
    check("single_lu_op", bus.lu_op, v.op);
    check("single_lu_a", bus.lu_a, v.a);
    check("single_lu_b", bus.lu_b, v.b);
    tick();
    check("single_wb_once", bus.wb_valid, 0);
    check("single_count_end", bus.count, 0);
  endtask

  // ---------------- stimulus ----------------
  vec_t fill_v [4];
  vec_t flush_v [4];
  vec_t v;

  initial begin
    fill_v[0]  = '{LOP_XOR,  32'hF0F0F0F0, 32'hFF00FF00, 5'd1,  32'h0FF00FF0};
    fill_v[1]  = '{LOP_NAND, 32'hFFFF0000, 32'hFF00FF00, 5'd2,  32'h00FFFFFF};
    fill_v[2]  = '{LOP_OR,   32'h12340000, 32'h00005678, 5'd3,  32'h12345678};
    fill_v[3]  = '{LOP_NOT,  32'h0000FFFF, 32'hDEADBEEF, 5'd4,  32'hFFFF0000};
    flush_v[0] = '{LOP_NOR,  32'h0F0F0000, 32'h00F00F00, 5'd5,  32'hF000F0FF};
    flush_v[1] = '{LOP_XNOR, 32'hAAAAAAAA, 32'h55555555, 5'd6,  32'h00000000};
    flush_v[2] = '{LOP_AND,  32'h11111111, 32'h33333333, 5'd8,  32'h11111111};
    flush_v[3] = '{LOP_OR,   32'h00000001, 32'h00000002, 5'd9,  32'h00000003};

    bus.in_valid = 1'b0;
    bus.in_op    = '0;
    bus.in_a     = '0;
    bus.in_b     = '0;
    bus.in_rd    = '0;
    bus.hold     = 1'b0;
    bus.flush    = 1'b0;

    // Reset state
    rst_n = 1'b0;
    repeat (2) tick();
    check("rst_count", bus.count, 0);
    check("rst_wb_valid", bus.wb_valid, 0);
    check("rst_wb_rd", bus.wb_rd, 0);
    check("rst_lu_op", bus.lu_op, 0);
    check("rst_lu_a", bus.lu_a, 0);
    check("rst_lu_b", bus.lu_b, 0);
    rst_n = 1'b1;
    tick();
    check("rst_in_ready", bus.in_ready, 1);

    // Single AND: 0x0001FFC1 & 0x000000BC = 0x80
    single('{LOP_AND, 32'h0001FFC1, 32'h000000BC, 5'd7, 32'h00000080});

    // Fill to full under hold, fifth push refused
    bus.hold = 1'b1;
    for (int i = 0; i < 4; i++) begin
      drive(fill_v[i]);
      expect_wb(fill_v[i]);
      check("fill_ready", bus.in_ready, 1);
      tick();
      check("fill_count", bus.count, i + 1);
    end
    drive('{LOP_NOR, 32'h0, 32'h0, 5'd30, 32'hFFFFFFFF});
    check("full_ready", bus.in_ready, 0);
    tick();
    check("full_refused_count", bus.count, 4);
    check("full_hold_no_issue", bus.wb_valid, 0);

    // Release hold while still offering: pop happens, push still refused
    bus.hold = 1'b0;
    drive('{LOP_AND, 32'h0, 32'h0, 5'd31, 32'h0});
    tick();
    idle();
    check("pop_full_count", bus.count, 3);
    check("pop_full_ready", bus.in_ready, 1);
    check("pop_full_wb", bus.wb_valid, 0);
    for (int i = 0; i < 4; i++) begin
      tick();
      check("drain_wb_valid", bus.wb_valid, 1);
      check("drain_wb_rd", bus.wb_rd, fill_v[i].rd);
    end
    tick();
    check("drain_wb_end", bus.wb_valid, 0);
    check("drain_count", bus.count, 0);

    // Flush with two queued, one in stage-1, one writeback already on the bus
    bus.hold = 1'b1;
    for (int i = 0; i < 4; i++) begin
      drive(flush_v[i]);
      if (i == 0) expect_wb(flush_v[i]);
      tick();
    end
    idle();
    check("flush_fill_count", bus.count, 4);
    bus.hold = 1'b0;
    tick();
    tick();
    check("flush_prior_wb_valid", bus.wb_valid, 1);
    check("flush_prior_wb_rd", bus.wb_rd, flush_v[0].rd);
    check("flush_prior_count", bus.count, 2);
    drive('{LOP_XOR, 32'h1, 32'h1, 5'd10, 32'h0});
    bus.flush = 1'b1;
    bus.hold  = 1'b1;
    tick();
    bus.flush = 1'b0;
    bus.hold  = 1'b0;
    idle();
    check("flush_count", bus.count, 0);
    check("flush_ready", bus.in_ready, 1);
    check("flush_wb_squashed", bus.wb_valid, 0);
    for (int i = 0; i < 3; i++) begin
      tick();
      check("flush_quiet_wb", bus.wb_valid, 0);
      check("flush_quiet_count", bus.count, 0);
    end

    // Reset one cycle after an issue: the in-flight result is discarded
    v = '{LOP_XOR, 32'h00000055, 32'h0000000F, 5'd12, 32'h0000005A};
    drive(v);
    tick();
    idle();
    if (WB_LAT == 2) tick();
    check("rst_mid_issued_op", bus.lu_op, v.op);
    check("rst_mid_issued_a", bus.lu_a, v.a);
    rst_n = 1'b0;
    tick();
    check("rst_mid_wb_valid", bus.wb_valid, 0);
    check("rst_mid_wb_rd", bus.wb_rd, 0);
    check("rst_mid_lu_op", bus.lu_op, 0);
    check("rst_mid_lu_a", bus.lu_a, 0);
    check("rst_mid_lu_b", bus.lu_b, 0);
    check("rst_mid_count", bus.count, 0);
    rst_n = 1'b1;
    tick();
    check("rst_mid_after_wb", bus.wb_valid, 0);
    check("rst_mid_after_ready", bus.in_ready, 1);

    // NEG of 1 = all ones; latency depends on bypass build
    single('{LOP_NEG, 32'h00000001, 32'h00000000, 5'd13, 32'hFFFFFFFF});

    repeat (3) tick();
    check("exp_q_drained", exp_q.size(), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
